// File: rtl/i2s_master_tx.sv
// -----------------------------------------------------------------------------
// i2s_master_tx
//
// I2S bus-master transmitter. Derives sck and ws from the codec master clock
// and shifts one stereo pair per frame out on sda, MSB first, in Philips
// format (ws changes one bit ahead of the MSB). Samples arrive through a
// single-pair valid/ready holding register and are moved into the active
// pair register on the tick that starts each frame.
//
// Parameters:
//   DATA_WIDTH  sample width per channel (<= SLOT_BITS)
//   SLOT_BITS   sck periods per channel slot
//   SCK_DIV     clk_12M cycles per sck period (even, >= 2)
//
// Ports:
//   clk_12M      in   codec master clock, sole clock
//   rstn         in   asynchronous active-low reset
//   en           in   run enable; low holds the bus idle
//   ldata/rdata  in   left/right sample, two's complement
//   in_valid     in   ldata/rdata pair is valid
//   in_ready     out  holding register is empty
//   sck          out  I2S bit clock
//   ws           out  I2S word select (0 = left, 1 = right)
//   sda          out  I2S serial data
//   frame_start  out  one-cycle pulse when a new pair starts
//   underrun     out  one-cycle pulse when no pair was held at frame start
//
// Build option:
//   I2S_TX_UNDERRUN_ZERO_EN  defined: an underrun frame is sent as zeros.
//                            undefined: an underrun frame repeats the last pair.
//
// Operating modes (selected directly by en, no extra state register):
//   mode | meaning
//   IDLE | en = 0: divider and bit position parked, sck/ws/sda low
//   RUN  | en = 1: divider running, one bit per sck period
// -----------------------------------------------------------------------------
module i2s_master_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_BITS  = 32,
    parameter int SCK_DIV    = 4
) (
    input  logic                  clk_12M,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] ldata,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  sck,
    output logic                  ws,
    output logic                  sda,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int DW = $clog2(SCK_DIV);
    localparam int PW = $clog2(2 * SLOT_BITS);

    localparam logic [DW-1:0] D_LAST = DW'(SCK_DIV - 1);
    localparam logic [DW-1:0] D_HALF = DW'(SCK_DIV / 2);
    localparam logic [PW-1:0] P_LAST = PW'(2 * SLOT_BITS - 1);
    localparam logic [PW-1:0] WS_LO  = PW'(SLOT_BITS - 1);
    localparam logic [PW-1:0] WS_HI  = PW'(2 * SLOT_BITS - 2);

    logic [DW-1:0]         d_q, d_d;
    logic [PW-1:0]         p_q, p_d;
    logic                  sck_q, sck_d;
    logic                  ws_q, ws_d;
    logic                  sda_q, sda_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0] act_l_q, act_l_d;
    logic [DATA_WIDTH-1:0] act_r_q, act_r_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic                  hold_full_q, hold_full_d;

    logic                  xfer;
    logic                  tick;

    assign xfer = in_valid && !hold_full_q;

    always_comb begin
        d_d           = d_q;
        p_d           = p_q;
        sck_d         = 1'b0;
        ws_d          = ws_q;
        sda_d         = sda_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        act_l_d       = act_l_q;
        act_r_d       = act_r_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        hold_full_d   = hold_full_q;
        tick          = 1'b0;

        // The handshake runs regardless of en so the source can refill
        // the holding register while the bus is parked.
        if (xfer) begin
            hold_l_d    = ldata;
            hold_r_d    = rdata;
            hold_full_d = 1'b1;
        end

        if (!en) begin
            d_d   = '0;
            p_d   = P_LAST;
            ws_d  = 1'b0;
            sda_d = 1'b0;
        end else begin
            tick  = (d_q == D_LAST);
            d_d   = tick ? '0 : d_q + DW'(1);
            sck_d = (d_d >= D_HALF);

            if (tick) begin
                p_d = (p_q == P_LAST) ? '0 : p_q + PW'(1);

                if (p_d == '0) begin
                    frame_start_d = 1'b1;
                    if (hold_full_q) begin
                        act_l_d     = hold_l_q;
                        act_r_d     = hold_r_q;
                        hold_full_d = 1'b0;
                    end else begin
                        // A pair arriving in this very cycle is still an
                        // underrun; it was captured above for the next frame.
                        underrun_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
                        act_l_d = '0;
                        act_r_d = '0;
`endif
                    end
                end

                ws_d = (p_d >= WS_LO) && (p_d <= WS_HI);

                // Bit select by position match; positions outside both
                // data windows are padding and stay 0.
                sda_d = 1'b0;
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (p_d == PW'(DATA_WIDTH - 1 - i)) begin
                        sda_d = act_l_d[i];
                    end
                    if (p_d == PW'(SLOT_BITS + DATA_WIDTH - 1 - i)) begin
                        sda_d = act_r_d[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_12M or negedge rstn) begin
        if (!rstn) begin
            d_q           <= '0;
            p_q           <= P_LAST;
            sck_q         <= 1'b0;
            ws_q          <= 1'b0;
            sda_q         <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            act_l_q       <= '0;
            act_r_q       <= '0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            hold_full_q   <= 1'b0;
        end else begin
            d_q           <= d_d;
            p_q           <= p_d;
            sck_q         <= sck_d;
            ws_q          <= ws_d;
            sda_q         <= sda_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            act_l_q       <= act_l_d;
            act_r_q       <= act_r_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            hold_full_q   <= hold_full_d;
        end
    end

    assign in_ready    = !hold_full_q;
    assign sck         = sck_q;
    assign ws          = ws_q;
    assign sda         = sda_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
module tb_i2s_master_tx;

    logic        clk_12M = 1'b0;
    logic        rstn;
    logic        en;
    logic [15:0] ldata;
    logic [15:0] rdata;
    logic        in_valid;
    logic        in_ready;
    logic        sck;
    logic        ws;
    logic        sda;
    logic        frame_start;
    logic        underrun;

    always #5 clk_12M = ~clk_12M;

    int cyc = 0;
    always @(posedge clk_12M) cyc <= cyc + 1;

    i2s_master_tx #(
        .DATA_WIDTH(16),
        .SLOT_BITS (32),
        .SCK_DIV   (4)
    ) dut (
        .clk_12M    (clk_12M),
        .rstn       (rstn),
        .en         (en),
        .ldata      (ldata),
        .rdata      (rdata),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sck        (sck),
        .ws         (ws),
        .sda        (sda),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        u;
    } frame_t;

    frame_t sb_q[$];

    task automatic push(input logic [15:0] l, input logic [15:0] r, input logic u);
        frame_t f;
        f.l = l;
        f.r = r;
        f.u = u;
        sb_q.push_back(f);
    endtask

    // Expected content of a frame that started without a held pair,
    // given the pair that was last loaded.
    task automatic push_urun(input logic [15:0] l, input logic [15:0] r);
`ifdef I2S_TX_UNDERRUN_ZERO_EN
        push(16'h0000, 16'h0000, 1'b1);
`else
        push(l, r, 1'b1);
`endif
    endtask

    // ---------------- bus monitor ----------------
    logic        in_frame = 1'b0;
    int          bit_cnt = 0;
    logic [63:0] fr_sda;
    logic [63:0] fr_ws;
    logic        fr_urun;
    logic        sck_prev = 1'b0;
    logic        ws_prev = 1'b0;
    int          last_rise = -1;
    int          last_ws = -1;
    logic        pre_sda = 1'b1;
    logic        pre_ws = 1'b1;
    logic [63:0] exp_ws;
    frame_t      m_exp;
    logic [15:0] m_l;
    logic [15:0] m_r;
    logic        m_pad;

    initial begin
        exp_ws = '0;
        for (int k = 31; k <= 62; k++) exp_ws[k] = 1'b1;
        forever begin
            @(negedge clk_12M);
            if (!rstn || !en) begin
                in_frame  = 1'b0;
                last_rise = -1;
                last_ws   = -1;
            end else begin
                if (frame_start) begin
                    in_frame = 1'b1;
                    bit_cnt  = 0;
                    fr_urun  = underrun;
                    fr_sda   = '0;
                    fr_ws    = '0;
                end
                if (sck && !sck_prev) begin
                    if (last_rise >= 0) check("sck_period", cyc - last_rise, 4);
                    last_rise = cyc;
                    if (in_frame) begin
                        fr_sda[bit_cnt] = sda;
                        fr_ws[bit_cnt]  = ws;
                        bit_cnt++;
                        if (bit_cnt == 64) begin
                            in_frame = 1'b0;
                            check("sb_avail", sb_q.size() > 0, 1);
                            if (sb_q.size() > 0) begin
                                m_exp = sb_q.pop_front();
                                m_pad = 1'b0;
                                for (int k = 0; k < 16; k++) begin
                                    m_l[15-k] = fr_sda[k];
                                    m_r[15-k] = fr_sda[32+k];
                                    m_pad     = m_pad | fr_sda[16+k] | fr_sda[48+k];
                                end
                                check("frame_left", m_l, m_exp.l);
                                check("frame_right", m_r, m_exp.r);
                                check("frame_pad", m_pad, 0);
                                check("frame_ws", fr_ws, exp_ws);
                                check("frame_urun", fr_urun, m_exp.u);
                            end
                        end
                    end else begin
                        pre_sda = sda;
                        pre_ws  = ws;
                    end
                end
                if (ws && !ws_prev) begin
                    if (last_ws >= 0) check("ws_period", cyc - last_ws, 256);
                    last_ws = cyc;
                end
            end
            sck_prev = sck;
            ws_prev  = ws;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [15:0] l, input logic [15:0] r, output int acc_cyc);
        logic ok;
        ok       = 1'b0;
        acc_cyc  = -1;
        ldata    = l;
        rdata    = r;
        in_valid = 1'b1;
        for (int k = 0; k < 600 && !ok; k++) begin
            ok      = in_ready;
            acc_cyc = cyc;
            @(negedge clk_12M);
        end
        in_valid = 1'b0;
        check("send_accept", ok, 1);
    endtask

    task automatic wait_fs(input string tag, output int n);
        logic found;
        found = 1'b0;
        n     = -1;
        for (int k = 1; k <= 600 && !found; k++) begin
            @(negedge clk_12M);
            if (frame_start) begin
                found = 1'b1;
                n     = k;
            end
        end
        check({tag, "_seen"}, found, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int t;
        int prev;
        int bad;

        rstn     = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        ldata    = '0;
        rdata    = '0;
        repeat (3) @(negedge clk_12M);
        check("rst_sck", sck, 0);
        check("rst_ws", ws, 0);
        check("rst_sda", sda, 0);
        check("rst_fs", frame_start, 0);
        check("rst_urun", underrun, 0);
        check("rst_rdy", in_ready, 1);

        rstn = 1'b1;
        bad  = 0;
        repeat (1000) begin
            @(negedge clk_12M);
            if (sck || ws || sda || frame_start || underrun || !in_ready) bad++;
        end
        check("idle_quiet", bad, 0);

        // Golden frame: pair held before enable goes out in frame 0.
        send(16'hA5C3, 16'h3C5A, t);
        push(16'hA5C3, 16'h3C5A, 1'b0);
        check("rdy_low", in_ready, 0);
        pre_sda = 1'b1;
        pre_ws  = 1'b1;
        en      = 1'b1;
        wait_fs("frame0", n);
        check("first_tick", n, 4);
        check("frame0_urun", underrun, 0);
        check("rdy_back", in_ready, 1);
        check("startup_sda", pre_sda, 0);
        check("startup_ws", pre_ws, 0);

        // Back-pressure: valid held, one acceptance per frame.
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            send(16'(16'h1100 + i), 16'(16'h2200 + i), t);
            push(16'(16'h1100 + i), 16'(16'h2200 + i), 1'b0);
            if (i > 0) check("bp_spacing", t - prev, 256);
            prev = t;
        end
        send(16'h1234, 16'h5678, t);
        check("bp_spacing", t - prev, 256);
        push(16'h1234, 16'h5678, 1'b0);
        check("rdy_low2", in_ready, 0);

        // Underrun: nothing offered for the frame after 1234/5678.
        push_urun(16'h1234, 16'h5678);
        wait_fs("frame5", n);
        check("frame5_urun", underrun, 0);
        wait_fs("frame6", n);
        check("urun_pulse", underrun, 1);

        // Late arrival: transfer on the exact frame-load edge.
        repeat (255) @(negedge clk_12M);
        check("late_rdy_pre", in_ready, 1);
        ldata    = 16'h8001;
        rdata    = 16'h7FFE;
        in_valid = 1'b1;
        @(negedge clk_12M);
        in_valid = 1'b0;
        check("late_fs", frame_start, 1);
        check("late_urun", underrun, 1);
        check("late_rdy", in_ready, 0);
        push_urun(16'h1234, 16'h5678);
        push(16'h8001, 16'h7FFE, 1'b0);
        wait_fs("frame8", n);
        check("frame8_urun", underrun, 0);

        // Enable drop at p=20 while a pair is held.
        wait_fs("frame9", n);
        check("frame9_urun", underrun, 1);
        send(16'hC0DE, 16'h0ACE, t);
        repeat (81) @(negedge clk_12M);
        check("drop_pre_sck", sck, 1);
        en = 1'b0;
        @(negedge clk_12M);
        check("drop_sck", sck, 0);
        check("drop_ws", ws, 0);
        check("drop_sda", sda, 0);
        check("drop_rdy", in_ready, 0);
        repeat (20) @(negedge clk_12M);
        check("hold_kept", in_ready, 0);
        push(16'hC0DE, 16'h0ACE, 1'b0);
        en = 1'b1;
        wait_fs("reen", n);
        check("reen_tick", n, 4);
        check("reen_urun", underrun, 0);
        check("reen_rdy", in_ready, 1);

        wait_fs("tail", n);
        check("tail_urun", underrun, 1);
        repeat (10) @(negedge clk_12M);
        en = 1'b0;
        repeat (10) @(negedge clk_12M);
        check("end_sck", sck, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
